// File: rtl/dhc_seq.sv
// dhc_seq: run controller for the direction-controlled hex counter.
//
// Turns start/stop requests into a divided count-enable pulse train, a one-cycle
// clear pulse and an up/down direction for the counter. In bounce mode the
// direction reverses at 0 and CNT_MAX; otherwise a wrap-around is flagged.
//
// Parameters:
//   DIV      clock cycles per count tick (2..256)
//   CNT_MAX  counter upper limit (counter wraps CNT_MAX <-> 0)
//   WIDTH    counter value width, CNT_MAX < 2**WIDTH
//
// Ports:
//   dhs_clk      rising-edge clock
//   dhs_rst      asynchronous active-low reset
//   dhs_start    start/resume request (level)
//   dhs_stop     pause/stop request (level)
//   dhs_dir      requested direction, 0 = up, 1 = down (non-bounce mode)
//   dhs_bounce   1 = reverse direction at the count limits
//   dhs_q        current counter value
//   dhs_cnt_en   one-cycle count enable to the counter
//   dhs_cnt_up   direction to the counter, 1 = up
//   dhs_cnt_clr  one-cycle synchronous clear to the counter
//   dhs_state    FSM state code (IDLE=0, RUN=1, PAUSE=2, CLEAR=3)
//   dhs_wrap     one-cycle wrap flag, one cycle after the wrapping count enable
//   dhs_wraps    saturating wrap count (only when DHS_WRAP_CNT_EN is defined)
//
// Build option: define DHS_WRAP_CNT_EN to add the dhs_wraps counter and port.

module dhc_seq #(
    parameter int unsigned DIV     = 4,
    parameter int unsigned CNT_MAX = 15,
    parameter int unsigned WIDTH   = 4
) (
    input  logic             dhs_clk,
    input  logic             dhs_rst,
    input  logic             dhs_start,
    input  logic             dhs_stop,
    input  logic             dhs_dir,
    input  logic             dhs_bounce,
    input  logic [WIDTH-1:0] dhs_q,
    output logic             dhs_cnt_en,
    output logic             dhs_cnt_up,
    output logic             dhs_cnt_clr,
    output logic [1:0]       dhs_state,
    output logic             dhs_wrap
`ifdef DHS_WRAP_CNT_EN
    ,
    output logic [7:0]       dhs_wraps
`endif
);

    localparam int unsigned PW = $clog2(DIV);
    localparam logic [PW-1:0] PreLast = PW'(DIV - 1);
    localparam logic [WIDTH-1:0] QMax = WIDTH'(CNT_MAX);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRun   = 2'd1,
        StPause = 2'd2,
        StClear = 2'd3
    } state_e;

    state_e        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic          up_q, up_d;
    logic          wrap_q, wrap_d;
    logic          cnt_en;

    assign cnt_en = (state_q == StRun) && (presc_q == PreLast);

    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        up_d    = up_q;
        case (state_q)
            StIdle: begin
                if (dhs_start && !dhs_stop) state_d = StClear;
            end
            StClear: begin
                presc_d = '0;
                up_d    = ~dhs_dir;
                state_d = dhs_stop ? StIdle : StRun;
            end
            StRun: begin
                presc_d = (presc_q == PreLast) ? '0 : presc_q + 1'b1;
                // Direction only changes at prescaler 0, so it never moves under a pulse.
                if (presc_q == '0) begin
                    if (dhs_bounce) begin
                        if (dhs_q == QMax) begin
                            up_d = 1'b0;
                        end else if (dhs_q == '0) begin
                            up_d = 1'b1;
                        end
                    end else begin
                        up_d = ~dhs_dir;
                    end
                end
                if (dhs_stop) state_d = StPause;
            end
            StPause: begin
                if (dhs_stop) begin
                    state_d = StIdle;
                end else if (dhs_start) begin
                    state_d = StRun;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // A count enable at a limit in the current direction wraps the counter.
    always_comb begin
        wrap_d = cnt_en && !dhs_bounce &&
                 ((up_q && (dhs_q == QMax)) || (!up_q && (dhs_q == '0)));
    end

    always_ff @(posedge dhs_clk or negedge dhs_rst) begin
        if (!dhs_rst) begin
            state_q <= StIdle;
            presc_q <= '0;
            up_q    <= 1'b1;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            up_q    <= up_d;
            wrap_q  <= wrap_d;
        end
    end

`ifdef DHS_WRAP_CNT_EN
    logic [7:0] wraps_q, wraps_d;

    always_comb begin
        wraps_d = wraps_q;
        if (state_q == StClear) begin
            wraps_d = '0;
        end else if (wrap_q && (wraps_q != 8'hff)) begin
            wraps_d = wraps_q + 8'd1;
        end
    end

    always_ff @(posedge dhs_clk or negedge dhs_rst) begin
        if (!dhs_rst) begin
            wraps_q <= '0;
        end else begin
            wraps_q <= wraps_d;
        end
    end

    assign dhs_wraps = wraps_q;
`endif

    assign dhs_cnt_en  = cnt_en;
    assign dhs_cnt_up  = up_q;
    assign dhs_cnt_clr = (state_q == StClear);
    assign dhs_state   = state_q;
    assign dhs_wrap    = wrap_q;

endmodule

// File: tb/tb_dhc_seq.sv
// Scoreboard bench for dhc_seq (DIV=4, CNT_MAX=15, WIDTH=4).
// The stimulus process pushes cycle-stamped expected outputs into a sorted queue;
// the monitor compares at every falling edge whenever an entry is due or the DUT
// shows an event (count enable, clear or wrap).

module tb_dhc_seq;

    logic       dhs_clk;
    logic       dhs_rst;
    logic       dhs_start;
    logic       dhs_stop;
    logic       dhs_dir;
    logic       dhs_bounce;
    logic [3:0] dhs_q;
    logic       dhs_cnt_en;
    logic       dhs_cnt_up;
    logic       dhs_cnt_clr;
    logic [1:0] dhs_state;
    logic       dhs_wrap;
`ifdef DHS_WRAP_CNT_EN
    logic [7:0] dhs_wraps;
`endif

    dhc_seq #(
        .DIV     (4),
        .CNT_MAX (15),
        .WIDTH   (4)
    ) dut (
        .dhs_clk     (dhs_clk),
        .dhs_rst     (dhs_rst),
        .dhs_start   (dhs_start),
        .dhs_stop    (dhs_stop),
        .dhs_dir     (dhs_dir),
        .dhs_bounce  (dhs_bounce),
        .dhs_q       (dhs_q),
        .dhs_cnt_en  (dhs_cnt_en),
        .dhs_cnt_up  (dhs_cnt_up),
        .dhs_cnt_clr (dhs_cnt_clr),
        .dhs_state   (dhs_state),
        .dhs_wrap    (dhs_wrap)
`ifdef DHS_WRAP_CNT_EN
        ,
        .dhs_wraps   (dhs_wraps)
`endif
    );

    typedef struct {
        int         cyc;
        string      name;
        logic       en;
        logic       clr;
        logic       wrap;
        logic       up;
        logic [1:0] st;
        logic [7:0] wraps;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    bit   done = 0;

    initial dhs_clk = 1'b0;
    always #5 dhs_clk = ~dhs_clk;

    always @(posedge dhs_clk) cyc <= cyc + 1;

    // Keep the queue ordered by cycle so entries may be pushed out of order.
    task automatic push(input int c, input string name, input logic en, input logic clr,
                        input logic wrap, input logic up, input logic [1:0] st,
                        input logic [7:0] wraps);
        exp_t e;
        int   i;
        e.cyc = c; e.name = name; e.en = en; e.clr = clr; e.wrap = wrap;
        e.up = up; e.st = st; e.wraps = wraps;
        i = 0;
        while (i < sb.size() && sb[i].cyc <= c) i++;
        sb.insert(i, e);
    endtask

    task automatic goto(input int c);
        while (cyc < c) begin
            @(posedge dhs_clk);
            #1;
        end
    endtask

    // Monitor / scoreboard checker.
    initial begin
        @(negedge dhs_rst);
        forever begin
            @(negedge dhs_clk);
            if (done) break;
            while (sb.size() > 0 && sb[0].cyc < cyc) begin
                checks++;
                failures++;
                $display("FAIL %s: entry for cycle %0d never checked (now %0d)",
                         sb[0].name, sb[0].cyc, cyc);
                void'(sb.pop_front());
            end
            if (sb.size() > 0 && sb[0].cyc == cyc) begin
                exp_t e;
                logic [5:0] act, req;
                bit bad;
                e = sb.pop_front();
                act = {dhs_cnt_en, dhs_cnt_clr, dhs_wrap, dhs_cnt_up, dhs_state};
                req = {e.en, e.clr, e.wrap, e.up, e.st};
                bad = (act !== req);
`ifdef DHS_WRAP_CNT_EN
                if (dhs_wraps !== e.wraps) bad = 1;
`endif
                checks++;
                if (bad) begin
                    failures++;
                    $display("FAIL %s @cyc %0d: {en,clr,wrap,up,state} got %b want %b, wraps got %0d want %0d",
                             e.name, cyc, act, req,
`ifdef DHS_WRAP_CNT_EN
                             dhs_wraps,
`else
                             e.wraps,
`endif
                             e.wraps);
                end
            end else if (dhs_cnt_en || dhs_cnt_clr || dhs_wrap) begin
                checks++;
                failures++;
                $display("FAIL unexpected_event @cyc %0d: en=%b clr=%b wrap=%b state=%0d, none expected",
                         cyc, dhs_cnt_en, dhs_cnt_clr, dhs_wrap, dhs_state);
            end
        end
        while (sb.size() > 0) begin
            checks++;
            failures++;
            $display("FAIL %s: entry for cycle %0d left unchecked", sb[0].name, sb[0].cyc);
            void'(sb.pop_front());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1);
    end

    // Stimulus.
    initial begin
        int k, run0, c0, run1, run2;
        dhs_rst = 1'b1;
        dhs_start = 1'b0; dhs_stop = 1'b0; dhs_dir = 1'b0; dhs_bounce = 1'b0; dhs_q = 4'd5;
        #1;
        dhs_rst = 1'b0;

        // Reset held with random inputs.
        for (int i = 0; i < 3; i++) begin
            @(posedge dhs_clk);
            #1;
            dhs_start  = 1'($urandom);
            dhs_stop   = 1'($urandom);
            dhs_dir    = 1'($urandom);
            dhs_bounce = 1'($urandom);
            dhs_q      = 4'($urandom);
            push(cyc, "reset_held", 0, 0, 0, 1, 2'd0, 8'd0);
        end
        @(posedge dhs_clk);
        #1;
        dhs_rst = 1'b1;
        dhs_start = 1'b0; dhs_stop = 1'b0; dhs_dir = 1'b0; dhs_bounce = 1'b0; dhs_q = 4'd5;
        push(cyc, "reset_release", 0, 0, 0, 1, 2'd0, 8'd0);
        goto(cyc + 1);
        push(cyc, "idle_after_reset", 0, 0, 0, 1, 2'd0, 8'd0);
        goto(cyc + 1);

        // Start: CLEAR next cycle, RUN after, pulses every 4th RUN cycle.
        k = cyc;
        dhs_start = 1'b1;
        push(k + 1, "clear_pulse", 0, 1, 0, 1, 2'd3, 8'd0);
        run0 = k + 2;
        push(run0 + 3,  "pulse_1", 1, 0, 0, 1, 2'd1, 8'd0);
        push(run0 + 7,  "pulse_2_wrap_src", 1, 0, 0, 1, 2'd1, 8'd0);
        push(run0 + 8,  "wrap_flag", 0, 0, 1, 1, 2'd1, 8'd0);
        push(run0 + 11, "pulse_3", 1, 0, 0, 1, 2'd1, 8'd1);
        goto(k + 1);
        dhs_start = 1'b0;

        // q=15 while counting up through the second pulse -> wrap one cycle later.
        goto(run0 + 4);
        dhs_q = 4'd15;
        goto(run0 + 8);
        dhs_q = 4'd5;

        // Bounce: q=15 at a sample point turns down; q=0 at the next turns up.
        goto(run0 + 12);
        dhs_bounce = 1'b1;
        dhs_q = 4'd15;
        push(run0 + 13, "bounce_turn_down", 0, 0, 0, 0, 2'd1, 8'd1);
        push(run0 + 15, "bounce_pulse_down", 1, 0, 0, 0, 2'd1, 8'd1);
        push(run0 + 17, "bounce_turn_up", 0, 0, 0, 1, 2'd1, 8'd1);
        push(run0 + 19, "bounce_pulse_up", 1, 0, 0, 1, 2'd1, 8'd1);
        goto(run0 + 13);
        dhs_q = 4'd0;
        goto(run0 + 17);
        dhs_q = 4'd15;
        goto(run0 + 20);
        dhs_bounce = 1'b0;
        dhs_q = 4'd5;

        // Stop at prescaler 2, hold PAUSE 10 cycles, resume straight into a pulse.
        goto(run0 + 22);
        dhs_stop = 1'b1;
        push(run0 + 23, "pause_entry", 0, 0, 0, 1, 2'd2, 8'd1);
        push(run0 + 32, "pause_held", 0, 0, 0, 1, 2'd2, 8'd1);
        push(run0 + 33, "resume_pulse", 1, 0, 0, 1, 2'd1, 8'd1);
        push(run0 + 36, "pause_again", 0, 0, 0, 1, 2'd2, 8'd1);
        push(run0 + 37, "stop_wins_idle", 0, 0, 0, 1, 2'd0, 8'd1);
        goto(run0 + 23);
        dhs_stop = 1'b0;
        goto(run0 + 32);
        dhs_start = 1'b1;
        goto(run0 + 33);
        dhs_start = 1'b0;
        goto(run0 + 35);
        dhs_stop = 1'b1;
        goto(run0 + 36);
        dhs_start = 1'b1;
        goto(run0 + 37);
        dhs_start = 1'b0;
        dhs_stop = 1'b0;

        // Restart, then reset in the middle of a pulse cycle.
        c0 = run0 + 38;
        goto(c0);
        dhs_start = 1'b1;
        push(c0 + 1, "clear_2", 0, 1, 0, 1, 2'd3, 8'd1);
        run1 = c0 + 2;
        push(run1 + 3, "pulse_before_reset", 1, 0, 0, 1, 2'd1, 8'd0);
        goto(c0 + 1);
        dhs_start = 1'b0;
        goto(run1 + 3);
        dhs_q = 4'd15;
        @(negedge dhs_clk);
        #1;
        dhs_rst = 1'b0;
        @(posedge dhs_clk);
        #1;
        push(cyc, "reset_mid_run", 0, 0, 0, 1, 2'd0, 8'd0);
        goto(run1 + 5);
        push(cyc, "reset_mid_run_held", 0, 0, 0, 1, 2'd0, 8'd0);
        dhs_rst = 1'b1;
        dhs_q = 4'd5;

        // Start after reset repeats CLEAR -> RUN.
        goto(run1 + 6);
        dhs_start = 1'b1;
        push(run1 + 7, "clear_after_reset", 0, 1, 0, 1, 2'd3, 8'd0);
        run2 = run1 + 8;
        push(run2 + 3, "pulse_after_reset", 1, 0, 0, 1, 2'd1, 8'd0);
        push(run2 + 7, "pulse_after_reset_2", 1, 0, 0, 1, 2'd1, 8'd0);
        goto(run1 + 7);
        dhs_start = 1'b0;
        goto(run2 + 9);
        done = 1'b1;
    end

endmodule

// File: doc/dhc_seq.md
# dhc_seq

Run controller for the direction-controlled hex counter. It turns start/stop requests into a divided count-enable pulse train, a clear pulse and an up/down direction for the counter. In bounce mode it reverses direction at the count limits; otherwise it flags wrap-around. It sits between the board buttons/switches and the counter, and observes the counter output to make its limit decisions.

## Interface
- DIV, 4: clock cycles per count tick; legal range 2..256.
- CNT_MAX, 15: counter upper limit; the counter wraps CNT_MAX↔0.
- WIDTH, 4: counter value width; CNT_MAX < 2**WIDTH.

- dhs_clk  in  1  rising-edge clock
- dhs_rst  in  1  reset, asynchronous, active-low
- dhs_start  in  1  start/resume request, level sampled each edge
- dhs_stop  in  1  pause/stop request, level sampled each edge
- dhs_dir  in  1  requested direction, 0 = up, 1 = down (non-bounce mode)
- dhs_bounce  in  1  1 = reverse direction at 0 and CNT_MAX
- dhs_q  in  WIDTH  current counter value
- dhs_cnt_en  out  1  one-cycle count enable to counter
- dhs_cnt_up  out  1  direction to counter, 1 = up
- dhs_cnt_clr  out  1  one-cycle synchronous clear to counter
- dhs_state  out  2  FSM state code
- dhs_wrap  out  1  one-cycle wrap flag
- dhs_wraps  out  8  wrap count (only with DHS_WRAP_CNT_EN)

## Operation
- States: IDLE=0, CLEAR=3, RUN=1, PAUSE=2.
- IDLE: stop → IDLE; start & !stop → CLEAR.
- CLEAR: lasts one cycle with dhs_cnt_clr=1, prescaler ← 0, dhs_cnt_up ← ~dhs_dir. Stop → IDLE; otherwise → RUN.
- RUN: the prescaler increments every cycle, 0..DIV-1, and then wraps to 0. stop → PAUSE. start is ignored.
- PAUSE: the prescaler holds. stop → IDLE, with stop taking priority over start. start → RUN, resuming from the held prescaler value.
- dhs_cnt_en = (state==RUN) && (prescaler==DIV-1). It is combinational from registers and is not gated by same-cycle stop.
- Direction sample: each RUN cycle with prescaler==0.
  - Non-bounce mode: dhs_cnt_up ← ~dhs_dir.
  - Bounce mode: q==CNT_MAX → 0; q==0 → 1; otherwise unchanged.
  - dhs_cnt_up changes only at a sample point. Because DIV≥2, it is always stable across a pulse.
- Wrap: on a dhs_cnt_en cycle with dhs_bounce=0, where (up && q==CNT_MAX) or (down && q==0), dhs_wrap=1 in the following cycle. Bounce mode never asserts dhs_wrap.
- Reset values: state IDLE, prescaler 0, dhs_cnt_en 0, dhs_cnt_clr 0, dhs_cnt_up 1, dhs_wrap 0, dhs_wraps 0.
- Reset asserted mid-operation forces all reset values immediately, with no pulse completion. Release is followed by IDLE.

## Timing
- start sampled at edge N: CLEAR during cycle N+1, RUN from N+2.
- First dhs_cnt_en occurs in the DIV-th RUN cycle; pulses then repeat every DIV cycles.
- stop sampled in RUN at prescaler=p: next cycle PAUSE with prescaler p+1 mod DIV. No pulse occurs in PAUSE.
- dhs_wrap lags its triggering dhs_cnt_en by exactly 1 cycle.
- Prescaler width is clog2(DIV).

## Configuration
- DHS_WRAP_CNT_EN defined:
  - Adds 8-bit register dhs_wraps, incremented on each dhs_wrap cycle and saturating at 255.
  - It is cleared by reset and in CLEAR state.
- Undefined: dhs_wraps port and register are absent. All other behaviour is identical.

## Test plan
- Reset low with random inputs → state=0, cnt_en=0, cnt_clr=0, cnt_up=1, wrap=0 while held and after release.
- DIV=4, start pulse at edge 0 → cnt_clr=1 for one cycle (state 3), then RUN. cnt_en pulses in RUN cycles 4, 8, 12, … with cnt_up=1 for dir=0.
- dir=0, bounce=0, q=15 driven during a pulse → dhs_wrap=1 next cycle only; with DHS_WRAP_CNT_EN, dhs_wraps 0→1.
- bounce=1 → q=15 at a sample point gives cnt_up=0 before the next pulse; q=0 at a sample point gives cnt_up=1. dhs_wrap stays 0.
- stop during RUN at prescaler=2 → PAUSE with no pulses for 10 cycles; start → first pulse in the first RUN cycle. start & stop together in PAUSE → IDLE.
- Reset asserted mid-RUN on a pulse cycle → cnt_en drops immediately, state=0; next start repeats the CLEAR→RUN sequence.
